// File: rtl/atm_pin_verifier.sv
// PIN entry and verification ahead of the ATM transaction controller.
// Captures keypad digits, checks them against the card's PIN, and enforces attempt and idle limits.
module atm_pin_verifier #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_card_present,
  input  logic [4*PIN_DIGITS-1:0]           i_ref_pin,
  input  logic                              i_key_valid,
  input  logic [3:0]                        i_key_code,
  output logic                              o_pin_ok,
  output logic                              o_pin_fail,
  output logic                              o_locked,
  output logic                              o_timeout,
  output logic                              o_busy,
  output logic [3:0]                        o_digits_entered,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] o_attempts_left,
  output logic [2:0]                        o_state
);

  localparam int AW = $clog2(MAX_ATTEMPTS+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = 4*PIN_DIGITS;
  localparam logic [3:0]    FULL    = 4'(PIN_DIGITS);
  localparam logic [AW-1:0] ATT_MAX = AW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ENTRY       = 3'd1,
    S_CHECK       = 3'd2,
    S_GRANTED     = 3'd3,
    S_LOCKED      = 3'd4,
    S_WAIT_REMOVE = 3'd5
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_ref;
  logic [BW-1:0] r_buf;
  logic [3:0]    r_digits;
  logic [AW-1:0] r_attempts;
  logic [TW-1:0] r_timer;
  logic          r_pin_ok;
  logic          r_pin_fail;
  logic          r_locked;
  logic          r_timeout;
  logic          r_busy;

  logic w_key_accepted;
  logic w_match;

  // Codes 0xD-0xF are not keys at all: no action and no timer reload.
  assign w_key_accepted = i_key_valid && (i_key_code <= 4'hC);
  assign w_match        = (r_digits == FULL) && (r_buf == r_ref);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ref      <= '0;
      r_buf      <= '0;
      r_digits   <= '0;
      r_attempts <= ATT_MAX;
      r_timer    <= '0;
      r_pin_ok   <= 1'b0;
      r_pin_fail <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_pin_ok   <= 1'b0;
      r_pin_fail <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_card_present) begin
            r_ref      <= i_ref_pin;
            r_attempts <= ATT_MAX;
            r_buf      <= '0;
            r_digits   <= '0;
            r_timer    <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (!i_card_present) begin
            r_buf    <= '0;
            r_digits <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_key_accepted) begin
            r_timer <= '0;
            if (i_key_code <= 4'd9) begin
              if (r_digits < FULL) begin
                r_buf    <= {r_buf[BW-5:0], i_key_code};
                r_digits <= r_digits + 4'd1;
              end
            end else if (i_key_code == 4'hA) begin
              r_buf    <= '0;
              r_digits <= '0;
            end else if (i_key_code == 4'hB) begin
              r_state <= S_CHECK;
            end else begin
              r_timeout <= 1'b1;
              r_buf     <= '0;
              r_digits  <= '0;
              r_busy    <= 1'b0;
              r_state   <= S_WAIT_REMOVE;
            end
          end else if (r_timer == T_LAST) begin
            r_timeout <= 1'b1;
            r_buf     <= '0;
            r_digits  <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_WAIT_REMOVE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CHECK: begin
          // Entered digits never survive the check, whatever the outcome.
          r_buf    <= '0;
          r_digits <= '0;
          r_timer  <= '0;
          if (!i_card_present) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_match) begin
            r_pin_ok <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_GRANTED;
          end else if (r_attempts == AW'(1)) begin
            r_attempts <= '0;
            r_locked   <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_LOCKED;
          end else begin
            r_attempts <= r_attempts - AW'(1);
            r_pin_fail <= 1'b1;
            r_state    <= S_ENTRY;
          end
        end
        S_GRANTED, S_WAIT_REMOVE: begin
          if (!i_card_present) r_state <= S_IDLE;
        end
        S_LOCKED: begin
          if (!i_card_present) begin
            r_locked <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pin_ok         = r_pin_ok;
  assign o_pin_fail       = r_pin_fail;
  assign o_locked         = r_locked;
  assign o_timeout        = r_timeout;
  assign o_busy           = r_busy;
  assign o_digits_entered = r_digits;
  assign o_attempts_left  = r_attempts;
  assign o_state          = r_state;

endmodule

// File: tb/tb_atm_pin_verifier.sv
// Bench for atm_pin_verifier: directed test-plan steps, then random keypad traffic,
// every cycle compared against a queue-based model of the PIN entry rules.
module tb_atm_pin_verifier;

  localparam int PD = 4;
  localparam int MA = 3;
  localparam int TO = 8;
  localparam int AW = $clog2(MA+1);

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_GRANTED = 3, M_LOCKED = 4, M_WAIT = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_card_present;
  logic [4*PD-1:0] i_ref_pin;
  logic            i_key_valid;
  logic [3:0]      i_key_code;
  logic            o_pin_ok, o_pin_fail, o_locked, o_timeout, o_busy;
  logic [3:0]      o_digits_entered;
  logic [AW-1:0]   o_attempts_left;
  logic [2:0]      o_state;

  atm_pin_verifier #(.PIN_DIGITS(PD), .MAX_ATTEMPTS(MA), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .i_card_present(i_card_present), .i_ref_pin(i_ref_pin),
    .i_key_valid(i_key_valid), .i_key_code(i_key_code), .o_pin_ok(o_pin_ok),
    .o_pin_fail(o_pin_fail), .o_locked(o_locked), .o_timeout(o_timeout), .o_busy(o_busy),
    .o_digits_entered(o_digits_entered), .o_attempts_left(o_attempts_left), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: digits held in queues, idle time as a plain count.
  int   m_mode, m_att, m_idle;
  int   m_ref[$];
  int   m_buf[$];
  logic e_ok, e_fail, e_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_att = MA; m_idle = 0;
    m_ref.delete(); m_buf.delete();
    e_ok = 1'b0; e_fail = 1'b0; e_to = 1'b0;
  endtask

  function automatic bit buf_matches();
    if (m_buf.size() != PD) return 1'b0;
    foreach (m_buf[i]) if (m_buf[i] != m_ref[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit acc;
    int code;
    e_ok = 1'b0; e_fail = 1'b0; e_to = 1'b0;
    acc  = i_key_valid && (i_key_code <= 4'hC);
    code = int'(i_key_code);
    case (m_mode)
      M_IDLE: if (i_card_present) begin
        m_ref.delete();
        for (int i = PD-1; i >= 0; i--) m_ref.push_back(int'(i_ref_pin[4*i +: 4]));
        m_att = MA; m_buf.delete(); m_idle = 0; m_mode = M_ENTRY;
      end
      M_ENTRY: begin
        if (!i_card_present) begin
          m_mode = M_IDLE; m_buf.delete();
        end else if (acc) begin
          m_idle = 0;
          if (code <= 9) begin
            if (m_buf.size() < PD) m_buf.push_back(code);
          end else if (code == 10) m_buf.delete();
          else if (code == 11) m_mode = M_CHECK;
          else begin e_to = 1'b1; m_mode = M_WAIT; m_buf.delete(); end
        end else begin
          m_idle++;
          if (m_idle == TO) begin e_to = 1'b1; m_mode = M_WAIT; m_buf.delete(); end
        end
      end
      M_CHECK: begin
        bit match;
        match = buf_matches();
        m_buf.delete();
        if (!i_card_present) m_mode = M_IDLE;
        else if (match) begin e_ok = 1'b1; m_mode = M_GRANTED; end
        else begin
          m_att--;
          if (m_att == 0) m_mode = M_LOCKED;
          else begin e_fail = 1'b1; m_mode = M_ENTRY; m_idle = 0; end
        end
      end
      default: if (!i_card_present) m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("pin_ok",   o_pin_ok,         e_ok);
    chk("pin_fail", o_pin_fail,       e_fail);
    chk("timeout",  o_timeout,        e_to);
    chk("locked",   o_locked,         (m_mode == M_LOCKED));
    chk("busy",     o_busy,           (m_mode == M_ENTRY) || (m_mode == M_CHECK));
    chk("digits",   o_digits_entered, m_buf.size());
    chk("attempts", o_attempts_left,  m_att);
    chk("state",    o_state,          m_mode);
  endtask

  task automatic step(input logic kv, input logic [3:0] code);
    i_key_valid = kv;
    i_key_code  = code;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  // Digits are packed first-digit-most-significant in the low 4*n bits.
  task automatic enter_pin(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) step(1'b1, seq[4*(n-1-i) +: 4]);
  endtask

  function automatic logic [4*PD-1:0] rand_pin();
    logic [4*PD-1:0] p;
    for (int i = 0; i < PD; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
    return p;
  endfunction

  initial begin
    reset = 1'b1; i_card_present = 1'b0; i_ref_pin = '0; i_key_valid = 1'b0; i_key_code = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    chk("rst_attempts", o_attempts_left, MA);
    reset = 1'b0;
    step(1'b0, 4'h0);

    // Correct PIN
    i_ref_pin = 16'h1234; i_card_present = 1'b1;
    step(1'b0, 4'h0);
    chk("t1_busy", o_busy, 1);
    enter_pin(32'h1234, 4);
    step(1'b1, 4'hB);
    chk("t1_in_check", o_state, M_CHECK);
    step(1'b0, 4'h0);
    chk("t1_ok", o_pin_ok, 1);
    chk("t1_att", o_attempts_left, 3);
    step(1'b0, 4'h0);
    chk("t1_ok_single", o_pin_ok, 0);
    i_card_present = 1'b0;
    step(1'b0, 4'h0);
    chk("t1_idle", o_state, M_IDLE);

    // Lockout after three wrong entries
    i_card_present = 1'b1;
    step(1'b0, 4'h0);
    for (int a = 1; a <= 3; a++) begin
      enter_pin(32'h1235, 4);
      step(1'b1, 4'hB);
      step(1'b0, 4'h0);
      if (a < 3) begin
        chk("lk_fail", o_pin_fail, 1);
        chk("lk_att", o_attempts_left, 3 - a);
      end else begin
        chk("lk_locked", o_locked, 1);
        chk("lk_att0", o_attempts_left, 0);
        chk("lk_nofail", o_pin_fail, 0);
      end
    end
    enter_pin(32'h1234, 4);
    step(1'b1, 4'hB);
    chk("lk_keys_ignored", o_digits_entered, 0);
    chk("lk_still_locked", o_locked, 1);
    i_card_present = 1'b0;
    step(1'b0, 4'h0);
    chk("lk_cleared", o_locked, 0);

    // Short and over-long entries, CLEAR
    i_card_present = 1'b1;
    step(1'b0, 4'h0);
    enter_pin(32'h123, 3);
    step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    chk("short_fail", o_pin_fail, 1);
    chk("short_att", o_attempts_left, 2);
    enter_pin(32'h12345, 5);
    chk("long_digits", o_digits_entered, 4);
    step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    chk("long_ok", o_pin_ok, 1);
    i_card_present = 1'b0;
    step(1'b0, 4'h0);
    i_card_present = 1'b1;
    step(1'b0, 4'h0);
    enter_pin(32'h12, 2);
    chk("clr_pre", o_digits_entered, 2);
    step(1'b1, 4'hA);
    chk("clr_digits", o_digits_entered, 0);
    chk("clr_att", o_attempts_left, 3);

    // Timeout after exactly TO idle cycles, ignored codes do not reload it
    step(1'b1, 4'h1);
    repeat (TO-1) step(1'b0, 4'h0);
    chk("to_early", o_timeout, 0);
    step(1'b0, 4'h0);
    chk("to_pulse", o_timeout, 1);
    chk("to_state", o_state, M_WAIT);
    i_card_present = 1'b0;
    step(1'b0, 4'h0);
    i_card_present = 1'b1;
    step(1'b0, 4'h0);
    step(1'b1, 4'h1);
    repeat (TO-1) step(1'b1, 4'hE);
    chk("toE_early", o_timeout, 0);
    step(1'b1, 4'hE);
    chk("toE_pulse", o_timeout, 1);
    step(1'b0, 4'h0);
    chk("toE_single", o_timeout, 0);
    i_card_present = 1'b0;
    step(1'b0, 4'h0);

    // Card pulled while in CHECK
    i_card_present = 1'b1;
    step(1'b0, 4'h0);
    enter_pin(32'h1234, 4);
    step(1'b1, 4'hB);
    i_card_present = 1'b0;
    step(1'b0, 4'h0);
    chk("rm_no_ok", o_pin_ok, 0);
    chk("rm_idle", o_state, M_IDLE);

    // Asynchronous reset in the middle of an entry
    i_card_present = 1'b1;
    step(1'b0, 4'h0);
    enter_pin(32'h1111, 4);
    step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    enter_pin(32'h12, 2);
    #3 reset = 1'b1;
    #1;
    chk("ar_digits", o_digits_entered, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_state", o_state, M_IDLE);
    chk("ar_att", o_attempts_left, MA);
    model_reset();
    check_all();
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 4'h0);
    chk("ar_new_att", o_attempts_left, 3);
    chk("ar_new_busy", o_busy, 1);

    // Random traffic; ref_pin changes every cycle to exercise its one-shot sampling
    for (int n = 0; n < 600; n++) begin
      int r;
      logic kv;
      logic [3:0] code;
      i_ref_pin = rand_pin();
      if (i_card_present && $urandom_range(0, 59) == 0) i_card_present = 1'b0;
      else if (!i_card_present && $urandom_range(0, 2) == 0) i_card_present = 1'b1;
      r = $urandom_range(0, 99);
      kv = 1'b1;
      code = 4'($urandom_range(0, 9));
      if (n % 100 > 88) kv = 1'b0;
      else if (r < 35) kv = 1'b0;
      else if (r < 60 && m_ref.size() == PD && m_buf.size() < PD) code = 4'(m_ref[m_buf.size()]);
      else if (r < 75) code = 4'($urandom_range(0, 9));
      else if (r < 82) code = 4'hB;
      else if (r < 85) code = 4'hA;
      else if (r < 87) code = 4'hC;
      else code = 4'($urandom_range(13, 15));
      step(kv, code);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
